// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for sub_bytes_seq: input block channel and output block channel.
// slave = the SubBytes block, master = the round datapath driving it.
interface sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: BYTES_PER_CYCLE sbox lanes walk the 16 bytes group by group.
// Optional SUB_BYTES_SEQ_PERF_EN adds a 16-bit completed-block counter port.

module sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  logic [7:0] w_inv;
  logic [7:0] w_sq;

  // x^254 is the GF(2^8) inverse (and maps 0 to 0 without a special case)
  always_comb begin
    w_sq  = sbox_in;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      w_sq  = gmul(w_sq, w_sq);
      w_inv = gmul(w_inv, w_sq);
    end
  end

  assign sbox_out = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sub_bytes_seq_if.slave bus,
  output logic           o_busy
`ifdef SUB_BYTES_SEQ_PERF_EN
  ,
  output logic [15:0]    o_blk_count
`endif
);
  localparam int BPC = BYTES_PER_CYCLE;
  localparam int N   = 16 / BPC;
  localparam int GW  = 8 * BPC;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $fatal(1, "sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_grp;
  logic [127:0]          r_work;
  logic [127:0]          r_out;
  logic [127:0]          w_out_nxt;
  logic [BPC-1:0][7:0]   w_sb_in;
  logic [BPC-1:0][7:0]   w_sb_out;
  logic                  w_accept;
  logic                  w_out_hs;
  logic                  w_last;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_out_hs = bus.out_valid & bus.out_ready;
  assign w_last   = (r_grp == 4'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (w_out_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    o_busy        = 1'b0;
    case (r_state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_RUN:   o_busy        = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Group g covers bytes g*BPC .. g*BPC+BPC-1; byte 0 sits in the top bits.
  always_comb begin
    w_sb_in = '0;
    for (int g = 0; g < N; g++)
      if (r_grp == 4'(g)) w_sb_in = r_work[127 - GW*g -: GW];
  end

  always_comb begin
    w_out_nxt = r_out;
    for (int g = 0; g < N; g++)
      if (r_grp == 4'(g)) w_out_nxt[127 - GW*g -: GW] = w_sb_out;
  end

  for (genvar k = 0; k < BPC; k++) begin : g_lane
    sbox u_sbox (
      .sbox_in  (w_sb_in[k]),
      .sbox_out (w_sb_out[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_work <= '0;
      r_out  <= '0;
      r_grp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_work <= bus.in_state;
          r_grp  <= '0;
        end
        S_RUN: begin
          r_out <= w_out_nxt;
          r_grp <= w_last ? 4'd0 : r_grp + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_state = r_out;

`ifdef SUB_BYTES_SEQ_PERF_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_blk_cnt <= '0;
    else if (w_out_hs) r_blk_cnt <= r_blk_cnt + 16'd1;
  end

  assign o_blk_count = r_blk_cnt;
`endif
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Sequential AES SubBytes stage. Accepts a 128-bit state block, passes its 16 bytes through BYTES_PER_CYCLE instances of the existing combinational `sbox` (ports `sbox_in`/`sbox_out`, 8-bit), and returns the substituted block.
- Sits between the AddRoundKey output and the ShiftRows input in the round datapath.
- Uses valid/ready handshakes on both sides. Trades area for latency through the parameter.

Parameters:
- BYTES_PER_CYCLE, 1, sbox instances and bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is a fatal elaboration error.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a new state
- in_state  input  128  input block; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  out_state holds a completed block
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  substituted block, same byte ordering
- busy  output  1  high in RUN

Behaviour:
- N = 16 / BYTES_PER_CYCLE groups; 4-bit group counter `grp`.
- FSM states: IDLE, RUN, DONE.
- Reset (async, any time, including mid-RUN or DONE):
  - state = IDLE, grp = 0.
  - Internal state register and out_state = 128'h0.
  - Outputs: in_ready = 1, out_valid = 0, busy = 0.
  - Any in-flight block is discarded silently.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_state into the working register, grp = 0, go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle, bytes grp*BPC .. grp*BPC+BPC-1 of the working register drive the sbox inputs.
  - Results are written back into the same byte positions of out_state at the edge. Other bytes are unchanged.
  - grp increments. When grp == N-1 at the edge: go to DONE, grp = 0.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid = 1. out_state is stable until the handshake.
  - On out_valid & out_ready: go to IDLE, out_valid drops next cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Latency:
  - out_valid rises exactly N rising edges after the accepting edge (16 for BPC=1, 1 for BPC=16).
  - Minimum initiation interval is N+2 cycles (accept, N RUN edges, DONE->IDLE).
- out_state changes only in RUN. It holds the last completed block through IDLE until the next block overwrites it group by group.
- Backpressure: out_ready low in DONE holds indefinitely with no data change.
- in_state may change freely after acceptance; the working register is the only source used.
- No X-propagation: every register has a reset value.

Optional Feature:
- Macro: SUB_BYTES_SEQ_PERF_EN.
- Defined:
  - Adds output port `blk_count` [15:0]. It increments by 1 on each out_valid & out_ready handshake.
  - It wraps from 16'hFFFF to 16'h0000 and resets to 0 on rst_n.
- Undefined:
  - The port and counter are absent.
  - All other behaviour and timing are identical.

Test Plan:
- FIPS-197 vector, BPC=1: in_state = 193de3bea0f4e22b9ac68d2ae9f84808 -> out_state = d42711aee0bf98f1b8b45de51e415230. out_valid rises 16 edges after accept.
- Single-byte spot checks, BPC=16: bytes 00, A1, B2, CC placed in bytes 0..3, remaining bytes 00 -> out bytes 0..3 = 63, 32, 37, 4B; remaining bytes = 63; latency 1 edge.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid stays 1, out_state constant, in_ready stays 0. Raise out_ready -> IDLE next edge.
- Reset mid-RUN: assert rst_n = 0 after 5 RUN edges (BPC=1) -> out_state = 0, out_valid = 0, in_ready = 1 immediately. Next block completes normally in 16 edges.
- Ignored input: toggle in_valid with new data during RUN -> no effect on result; only the first accepted block is produced.
- With SUB_BYTES_SEQ_PERF_EN: 3 back-to-back blocks -> blk_count = 3. Preload 16'hFFFF via 65535 transactions or force -> wraps to 0.
